// File: rtl/hall_pkg.sv
// Shared sector encodings, FSM state type and commutation helpers for the
// six-step hall commutator.
package hall_pkg;

  localparam logic [2:0] SECT_S1     = 3'b101;
  localparam logic [2:0] SECT_S2     = 3'b100;
  localparam logic [2:0] SECT_S3     = 3'b110;
  localparam logic [2:0] SECT_S4     = 3'b010;
  localparam logic [2:0] SECT_S5     = 3'b011;
  localparam logic [2:0] SECT_S6     = 3'b001;
  localparam logic [2:0] ILLEGAL_000 = 3'b000;
  localparam logic [2:0] ILLEGAL_111 = 3'b111;

  // Sector index 0..5 stands for S1..S6; SECT_NONE marks an illegal code.
  localparam logic [2:0] SECT_NONE   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEADTIME,
    ST_DRIVE,
    ST_FAULT
  } state_t;

  function automatic logic hall_legal(input logic [2:0] h);
    return !((h == ILLEGAL_000) || (h == ILLEGAL_111));
  endfunction

  function automatic logic [2:0] sector_index(input logic [2:0] h);
    case (h)
      SECT_S1: return 3'd0;
      SECT_S2: return 3'd1;
      SECT_S3: return 3'd2;
      SECT_S4: return 3'd3;
      SECT_S5: return 3'd4;
      SECT_S6: return 3'd5;
      default: return SECT_NONE;
    endcase
  endfunction

  function automatic logic [2:0] sector_inc(input logic [2:0] idx);
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [2:0] sector_dec(input logic [2:0] idx);
    return (idx == 3'd0) ? 3'd5 : idx - 3'd1;
  endfunction

  // Returns {high[2:0], low[2:0]}, bit 2 = phase A.
  function automatic logic [5:0] drive_pattern(input logic [2:0] idx,
                                               input logic       dir,
                                               input logic       brk);
    logic [2:0] hi;
    logic [2:0] lo;
    hi = 3'b000;
    lo = 3'b000;
    case (idx)
      3'd0: begin hi = 3'b100; lo = 3'b010; end
      3'd1: begin hi = 3'b100; lo = 3'b001; end
      3'd2: begin hi = 3'b010; lo = 3'b001; end
      3'd3: begin hi = 3'b010; lo = 3'b100; end
      3'd4: begin hi = 3'b001; lo = 3'b100; end
      3'd5: begin hi = 3'b001; lo = 3'b010; end
      default: ;
    endcase
    if (brk) return {3'b000, 3'b111};
    return dir ? {hi, lo} : {lo, hi};
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser for the raw hall pins followed by a stability counter
// that only lets a value through after DEBOUNCE_CYCLES identical samples.
module hall_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_hall,
  output logic [2:0] o_hall_filt,
  output logic       o_filt_upd
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_cand;
  logic [2:0]    r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_upd;
  logic [CW-1:0] w_cnt_next;

  // r_cnt is the run length of r_cand; a new sample value restarts it at 1.
  always_comb begin
    // NOTE: default first so every path assigns w_cnt_next and no latch is inferred.
    w_cnt_next = CW'(1);
    if (r_sync2 == r_cand)
      w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_cand  <= 3'b000;
      r_filt  <= 3'b000;
      r_cnt   <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_sync1 <= i_hall;
      r_sync2 <= r_sync1;
      r_cand  <= r_sync2;
      r_cnt   <= w_cnt_next;
      r_upd   <= 1'b0;
      if ((w_cnt_next == CNT_MAX) && (r_sync2 != r_filt)) begin
        r_filt <= r_sync2;
        r_upd  <= 1'b1;
      end
    end
  end

  assign o_hall_filt = r_filt;
  assign o_filt_upd  = r_upd;

endmodule

// File: rtl/hall_commutator.sv
// Six-step BLDC commutation controller: debounced hall decode, dead-time
// insertion on every pattern change, latched hall faults and step odometry.
module hall_commutator
  import hall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int DEADTIME_CYCLES = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           hall,
  input  logic                 en,
  input  logic                 direction,
  input  logic                 brake,
  input  logic                 fault_clr,
  output logic [2:0]           phase_h,
  output logic [2:0]           phase_l,
  output logic                 hall_fault,
  output logic                 skip_err,
  output logic                 step_strobe,
  output logic [CNT_WIDTH-1:0] step_count,
  output logic [2:0]           hall_filt
);

  localparam int DT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYCLES - 1);

  logic [2:0]           w_hall_filt;
  logic                 w_upd;
  logic                 w_legal;
  logic                 w_seen;
  logic [2:0]           w_new_idx;
  logic [2:0]           w_old_idx;
  logic [5:0]           w_target;

  state_t               r_state;
  logic [DT_W-1:0]      r_dt_cnt;
  logic [2:0]           r_phase_h;
  logic [2:0]           r_phase_l;
  logic                 r_fault;
  logic [2:0]           r_filt_d;
  logic                 r_seen;
  logic                 r_strobe;
  logic                 r_skip;
  logic [CNT_WIDTH-1:0] r_count;

  hall_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .i_hall     (hall),
    .o_hall_filt(w_hall_filt),
    .o_filt_upd (w_upd)
  );

  // Right after reset hall_filt holds 000 without a real sample behind it;
  // the fault check only arms once the filter has loaded a value.
  assign w_seen    = r_seen | w_upd;
  assign w_legal   = hall_legal(w_hall_filt);
  assign w_new_idx = sector_index(w_hall_filt);
  assign w_old_idx = sector_index(r_filt_d);
  assign w_target  = drive_pattern(w_new_idx, direction, brake);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_dt_cnt  <= '0;
      r_phase_h <= 3'b000;
      r_phase_l <= 3'b000;
      r_fault   <= 1'b0;
    end else if (w_seen && !w_legal) begin
      r_state   <= ST_FAULT;
      r_phase_h <= 3'b000;
      r_phase_l <= 3'b000;
      r_fault   <= 1'b1;
    end else if (r_state == ST_FAULT) begin
      // Latched: only an explicit clear with a legal hall releases it.
      if (fault_clr) begin
        r_state <= ST_IDLE;
        r_fault <= 1'b0;
      end
    end else if (!en) begin
      r_state   <= ST_IDLE;
      r_phase_h <= 3'b000;
      r_phase_l <= 3'b000;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_legal) begin
            r_state  <= ST_DEADTIME;
            r_dt_cnt <= '0;
          end
        end
        ST_DEADTIME: begin
          if (r_dt_cnt == DT_LAST) begin
            r_state                <= ST_DRIVE;
            {r_phase_h, r_phase_l} <= w_target;
          end else begin
            r_dt_cnt <= r_dt_cnt + DT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (w_target != {r_phase_h, r_phase_l}) begin
            r_state   <= ST_DEADTIME;
            r_dt_cnt  <= '0;
            r_phase_h <= 3'b000;
            r_phase_l <= 3'b000;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Odometry runs regardless of drive state or enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt_d <= 3'b000;
      r_seen   <= 1'b0;
      r_strobe <= 1'b0;
      r_skip   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_filt_d <= w_hall_filt;
      r_strobe <= 1'b0;
      r_skip   <= 1'b0;
      if (w_upd) r_seen <= 1'b1;
      if (w_upd && (w_old_idx != SECT_NONE) && (w_new_idx != SECT_NONE)) begin
        if (w_new_idx == sector_inc(w_old_idx)) begin
          r_strobe <= 1'b1;
          r_count  <= r_count + CNT_WIDTH'(1);
        end else if (w_new_idx == sector_dec(w_old_idx)) begin
          r_strobe <= 1'b1;
          r_count  <= r_count - CNT_WIDTH'(1);
        end else begin
          r_skip <= 1'b1;
        end
      end
    end
  end

  assign phase_h     = r_phase_h;
  assign phase_l     = r_phase_l;
  assign hall_fault  = r_fault;
  assign skip_err    = r_skip;
  assign step_strobe = r_strobe;
  assign step_count  = r_count;
  assign hall_filt   = w_hall_filt;

endmodule

// File: tb/tb_hall_commutator.sv
// Scoreboard bench for hall_commutator: stimulus queues the expected output
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_hall_commutator;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hall;
  logic        en;
  logic        direction;
  logic        brake;
  logic        fault_clr;
  logic [2:0]  phase_h;
  logic [2:0]  phase_l;
  logic        hall_fault;
  logic        skip_err;
  logic        step_strobe;
  logic [15:0] step_count;
  logic [2:0]  hall_filt;

  always #5 clk = ~clk;

  hall_commutator #(
    .DEBOUNCE_CYCLES(8),
    .DEADTIME_CYCLES(4),
    .CNT_WIDTH      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hall       (hall),
    .en         (en),
    .direction  (direction),
    .brake      (brake),
    .fault_clr  (fault_clr),
    .phase_h    (phase_h),
    .phase_l    (phase_l),
    .hall_fault (hall_fault),
    .skip_err   (skip_err),
    .step_strobe(step_strobe),
    .step_count (step_count),
    .hall_filt  (hall_filt)
  );

  // val = {phase_h, phase_l, hall_fault}; lat = cycles since the last
  // hall_filt change, gap = cycles since the previous output change (0 = any).
  typedef struct {
    logic [6:0] val;
    int         lat;
    int         gap;
  } out_exp_t;

  out_exp_t    q_out[$];
  logic [17:0] q_step[$];
  logic [2:0]  q_filt[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Hand-written S1..S6 codes and forward table.
  logic [2:0] sect_code [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic [2:0] fwd_h     [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
  logic [2:0] fwd_l     [6] = '{3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_exp_t mk(input logic [6:0] v, input int lat, input int gap);
    out_exp_t e;
    e.val = v;
    e.lat = lat;
    e.gap = gap;
    return e;
  endfunction

  // Monitor
  int         cyc = 0;
  int         t_filt = 0;
  int         t_out = 0;
  logic [2:0] p_filt = 3'b000;
  logic [6:0] p_out = 7'b0;

  always @(negedge clk) begin
    out_exp_t    e;
    logic [17:0] s;
    logic [2:0]  f;
    cyc++;
    if (mon_en) begin
      if (hall_filt !== p_filt) begin
        if (q_filt.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_filt: got %b expected no change", hall_filt);
        end else begin
          f = q_filt.pop_front();
          check("hall_filt", {29'b0, hall_filt}, {29'b0, f});
        end
        t_filt = cyc;
      end
      if ({phase_h, phase_l, hall_fault} !== p_out) begin
        if (q_out.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got %b expected no change", {phase_h, phase_l, hall_fault});
        end else begin
          e = q_out.pop_front();
          check("outputs", {25'b0, phase_h, phase_l, hall_fault}, {25'b0, e.val});
          if (e.lat != 0) check("filt_to_out_latency", cyc - t_filt, e.lat);
          if (e.gap != 0) check("deadtime_gap", cyc - t_out, e.gap);
        end
        t_out = cyc;
      end
      if (step_strobe || skip_err) begin
        if (q_step.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_step: got strobe=%b skip=%b cnt=%h", step_strobe, skip_err, step_count);
        end else begin
          s = q_step.pop_front();
          check("step_event", {14'b0, step_strobe, skip_err, step_count}, {14'b0, s});
        end
      end
      check("no_overlap", {29'b0, phase_h & phase_l}, 32'd0);
    end
    p_filt = hall_filt;
    p_out  = {phase_h, phase_l, hall_fault};
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Move the pins to sector s while driving; kind 1 = strobe, 2 = skip.
  task automatic move(input int s, input int kind, input logic [15:0] cnt);
    q_filt.push_back(sect_code[s]);
    q_out.push_back(mk(7'b0, 1, 0));
    q_out.push_back(mk({fwd_h[s], fwd_l[s], 1'b0}, 5, 4));
    if (kind == 1) q_step.push_back({2'b10, cnt});
    if (kind == 2) q_step.push_back({2'b01, cnt});
    hall = sect_code[s];
    wait_cyc(20);
  endtask

  initial begin
    rst = 1'b1; hall = 3'b101; en = 1'b0; direction = 1'b1; brake = 1'b0; fault_clr = 1'b0;
    wait_cyc(3);
    check("rst_phase_h", {29'b0, phase_h}, 32'd0);
    check("rst_phase_l", {29'b0, phase_l}, 32'd0);
    check("rst_fault", {31'b0, hall_fault}, 32'd0);
    check("rst_skip", {31'b0, skip_err}, 32'd0);
    check("rst_strobe", {31'b0, step_strobe}, 32'd0);
    check("rst_count", {16'b0, step_count}, 32'd0);
    check("rst_filt", {29'b0, hall_filt}, 32'd0);

    // Startup in S1: filt after 2+8, then 4 off cycles, then A high / B low.
    q_filt.push_back(3'b101);
    q_out.push_back(mk({3'b100, 3'b010, 1'b0}, 5, 0));
    mon_en = 1'b1;
    rst = 1'b0; en = 1'b1;
    wait_cyc(20);

    // Two forward revolutions.
    for (int k = 0; k < 12; k++) move((k + 1) % 6, 1, 16'(k + 1));
    check("count_after_fwd", {16'b0, step_count}, 32'd12);

    // Mid-operation reset, then restart in S1 with count 0.
    q_filt.push_back(3'b000);
    q_out.push_back(mk(7'b0, 0, 0));
    rst = 1'b1;
    wait_cyc(2);
    check("count_mid_rst", {16'b0, step_count}, 32'd0);
    q_filt.push_back(3'b101);
    q_out.push_back(mk({3'b100, 3'b010, 1'b0}, 5, 0));
    rst = 1'b0;
    wait_cyc(20);

    // Backwards below zero wraps, then forward to S2.
    move(5, 1, 16'hFFFF);
    move(0, 1, 16'h0000);
    move(1, 1, 16'h0001);

    // Direction toggle in S2: dead time then swapped pattern, and back.
    q_out.push_back(mk(7'b0, 0, 0));
    q_out.push_back(mk({3'b001, 3'b100, 1'b0}, 0, 4));
    direction = 1'b0;
    wait_cyc(20);
    q_out.push_back(mk(7'b0, 0, 0));
    q_out.push_back(mk({3'b100, 3'b001, 1'b0}, 0, 4));
    direction = 1'b1;
    wait_cyc(20);

    // 3-cycle glitch is filtered out.
    hall = 3'b000;
    wait_cyc(3);
    hall = 3'b100;
    wait_cyc(20);
    check("glitch_filt", {29'b0, hall_filt}, 32'h4);

    // S2 -> S1 (count back to 0), then skip S1 -> S4.
    move(0, 1, 16'h0000);
    move(3, 2, 16'h0000);

    // Illegal hall latches a fault; clear is ignored while still illegal.
    q_filt.push_back(3'b000);
    q_out.push_back(mk({6'b0, 1'b1}, 1, 0));
    hall = 3'b000;
    wait_cyc(20);
    fault_clr = 1'b1;
    wait_cyc(1);
    fault_clr = 1'b0;
    wait_cyc(10);
    check("fault_held", {31'b0, hall_fault}, 32'd1);
    q_filt.push_back(3'b110);
    hall = 3'b110;
    wait_cyc(20);
    check("fault_still", {31'b0, hall_fault}, 32'd1);
    q_out.push_back(mk(7'b0, 0, 0));
    q_out.push_back(mk({3'b010, 3'b001, 1'b0}, 0, 5));
    fault_clr = 1'b1;
    wait_cyc(1);
    fault_clr = 1'b0;
    wait_cyc(20);

    // Brake in and out, each through dead time.
    q_out.push_back(mk(7'b0, 0, 0));
    q_out.push_back(mk({3'b000, 3'b111, 1'b0}, 0, 4));
    brake = 1'b1;
    wait_cyc(20);
    q_out.push_back(mk(7'b0, 0, 0));
    q_out.push_back(mk({3'b010, 3'b001, 1'b0}, 0, 4));
    brake = 1'b0;
    wait_cyc(20);

    // en drops during dead time: no pattern appears.
    q_filt.push_back(3'b010);
    q_out.push_back(mk(7'b0, 1, 0));
    q_step.push_back({2'b10, 16'h0001});
    hall = 3'b010;
    begin
      int n = 0;
      while (hall_filt !== 3'b010 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("filt_wait", {29'b0, hall_filt}, 32'h2);
    end
    wait_cyc(2);
    en = 1'b0;
    wait_cyc(20);
    check("en_off_h", {29'b0, phase_h}, 32'd0);
    check("en_off_l", {29'b0, phase_l}, 32'd0);
    q_out.push_back(mk({3'b010, 3'b100, 1'b0}, 0, 0));
    en = 1'b1;
    wait_cyc(20);

    begin
      int n = 0;
      while ((q_out.size() + q_step.size() + q_filt.size()) != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("q_out_empty", q_out.size(), 32'd0);
    check("q_step_empty", q_step.size(), 32'd0);
    check("q_filt_empty", q_filt.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
